regfile_writeback_port: RTL

- Write-side driver for the 32x32 register file; MEM/WB stage of the pipelined MIPS core.
- Merges two result sources into the register file's single write port (dest_address, writeBack_data, reg_write):
  - in-order pipeline results (ALU or load), which have priority;
  - a multi-cycle mul/div unit over a valid/ready handshake, buffered in a small FIFO.
- Formats load data (byte/half/word, sign/zero extension), suppresses writes to $0, and raises forwarding hits for the ID stage.
  - Needed because the register file reads on the same negedge it writes, so ID reads the old value.

---
 rtl/regfile_writeback_port_if.sv | 12 +
 rtl/regfile_writeback_port.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback_port_if.sv
// Mul/div result handshake into the writeback port: valid/ready with destination and value.
interface regfile_writeback_port_if #(
  parameter int DATA_W = 32
);
  logic              md_valid;
  logic              md_ready;
  logic [4:0]        md_dest;
  logic [DATA_W-1:0] md_result;

  modport master (output md_valid, output md_dest, output md_result, input md_ready);
  modport slave  (input md_valid, input md_dest, input md_result, output md_ready);
endinterface

// File: rtl/regfile_writeback_port.sv
// MEM/WB writeback driver: pipeline results win the register-file write port, mul/div results queue in a FIFO.
// Optional retire counter on output retire_count is built when WB_RETIRE_CNT_EN is defined.
module regfile_writeback_port #(
  parameter int MD_FIFO_DEPTH = 2,
  parameter int DATA_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_valid,
  input  logic              mem_reg_write,
  input  logic              mem_to_reg,
  input  logic [4:0]        mem_dest,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_load_data,
  input  logic [1:0]        mem_load_size,
  input  logic              mem_load_unsigned,
  regfile_writeback_port_if.slave md,
  output logic              md_pending,
  input  logic [4:0]        id_rs_address,
  input  logic [4:0]        id_rt_address,
  output logic [4:0]        dest_address,
  output logic [DATA_W-1:0] writeBack_data,
  output logic              reg_write,
  output logic              fwd_rs_hit,
  output logic              fwd_rt_hit
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [31:0]       retire_count
`endif
);

  localparam int PTR_W = (MD_FIFO_DEPTH > 1) ? $clog2(MD_FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MD_FIFO_DEPTH);

  logic [4:0]        fifo_dest [MD_FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [MD_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg;
  logic [PTR_W-1:0]  rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [CNT_W-1:0]  count_next;
  logic              md_ready_reg;

  logic              reg_write_reg;
  logic              reg_write_next;
  logic [4:0]        dest_reg;
  logic [4:0]        dest_next;
  logic [DATA_W-1:0] data_reg;
  logic [DATA_W-1:0] data_next;

  logic [7:0]        byte_lane [4];
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [DATA_W-1:0] load_fmt;

  logic              pipe_commit;
  logic              fifo_pop;
  logic              fifo_push;

  // Little-endian byte lanes of the loaded word
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign byte_lane[gi] = mem_load_data[8*gi +: 8];
    end
  endgenerate

  assign sel_byte = byte_lane[mem_alu_result[1:0]];
  assign sel_half = mem_alu_result[1] ? mem_load_data[31:16] : mem_load_data[15:0];

  always_comb begin
    load_fmt = mem_load_data;
    case (mem_load_size)
      2'b01: load_fmt = mem_load_unsigned ? {{(DATA_W-16){1'b0}}, sel_half}
                                          : {{(DATA_W-16){sel_half[15]}}, sel_half};
      2'b10: load_fmt = mem_load_unsigned ? {{(DATA_W-8){1'b0}}, sel_byte}
                                          : {{(DATA_W-8){sel_byte[7]}}, sel_byte};
      default: load_fmt = mem_load_data;
    endcase
  end

  assign pipe_commit = mem_valid & mem_reg_write & (mem_dest != 5'd0);
  assign fifo_pop    = ~pipe_commit & (count_reg != '0);
  // Writes to $0 complete the handshake but never occupy a slot
  assign fifo_push   = md.md_valid & md_ready_reg & (md.md_dest != 5'd0);

  always_comb begin
    reg_write_next = 1'b0;
    dest_next      = dest_reg;
    data_next      = data_reg;
    if (pipe_commit) begin
      reg_write_next = 1'b1;
      dest_next      = mem_dest;
      data_next      = mem_to_reg ? load_fmt : mem_alu_result;
    end else if (fifo_pop) begin
      reg_write_next = 1'b1;
      dest_next      = fifo_dest[rd_ptr_reg];
      data_next      = fifo_data[rd_ptr_reg];
    end
  end

  always_comb begin
    case ({fifo_push, fifo_pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_dest[wr_ptr_reg] <= md.md_dest;
      fifo_data[wr_ptr_reg] <= md.md_result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_reg <= 1'b0;
      dest_reg      <= 5'd0;
      data_reg      <= '0;
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      md_ready_reg  <= 1'b0;
    end else begin
      reg_write_reg <= reg_write_next;
      dest_reg      <= dest_next;
      data_reg      <= data_next;
      count_reg     <= count_next;
      // Ready tracks the registered count only, so a pop never opens a slot in the same cycle
      md_ready_reg  <= (count_next < DEPTH_C);
      if (fifo_push) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (fifo_pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
    end
  end

`ifdef WB_RETIRE_CNT_EN
  logic [31:0] retire_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_count_reg <= 32'd0;
    end else if (reg_write_next) begin
      retire_count_reg <= retire_count_reg + 32'd1;
    end
  end

  assign retire_count = retire_count_reg;
`endif

  assign md.md_ready      = md_ready_reg;
  assign md_pending       = (count_reg != '0);
  assign reg_write        = reg_write_reg;
  assign dest_address     = dest_reg;
  assign writeBack_data   = data_reg;

  // ID reads the old value on the write negedge, so the write in flight is forwarded
  assign fwd_rs_hit = reg_write_reg & (dest_reg == id_rs_address) & (id_rs_address != 5'd0);
  assign fwd_rt_hit = reg_write_reg & (dest_reg == id_rt_address) & (id_rt_address != 5'd0);

endmodule
